// File: rtl/lsu_mem_stage.sv
// RV32I MEM-stage load/store unit: one op per handshake, word-wide data-memory
// port, byte-lane steering for stores and sign/zero extension for loads.
module lsu_mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic                      op_is_store,
  input  logic [2:0]                op_funct3,
  input  logic [DATA_WIDTH-1:0]     op_addr,
  input  logic [DATA_WIDTH-1:0]     op_wdata,
  input  logic [4:0]                op_rd,
  input  logic                      flush,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [3:0]                mem_req_be,
  output logic [DATA_WIDTH-1:0]     mem_req_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
  output logic                      res_valid,
  output logic [DATA_WIDTH-1:0]     res_data,
  output logic [4:0]                res_rd,
  output logic                      res_we,
  output logic                      res_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic                      is_store_q;
  logic [2:0]                funct3_q;
  logic [1:0]                k_q;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic [4:0]                rd_q;
  logic                      kill_q;

  logic                      capture;
  logic                      legal_f3;
  logic                      misaligned;
  logic                      op_err;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     load_ext;
  logic [3:0]                st_be;
  logic [DATA_WIDTH-1:0]     st_wdata;
  logic                      res_fire;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^op_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH+2];

  always_comb begin
    capture = op_valid && (state == S_IDLE) && !flush;
    case (op_funct3)
      3'd0, 3'd1, 3'd2: legal_f3 = 1'b1;
      3'd4, 3'd5:       legal_f3 = !op_is_store;
      default:          legal_f3 = 1'b0;
    endcase
    case (op_funct3[1:0])
      2'd1:    misaligned = op_addr[0];
      2'd2:    misaligned = |op_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    op_err = !legal_f3 || misaligned;
  end

  always_comb begin
    shifted = mem_rsp_rdata >> {k_q, 3'b000};
    case (funct3_q)
      3'd0:    load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'd4:    load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'd5:    load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_ext = mem_rsp_rdata;
    endcase
    case (funct3_q[1:0])
      2'd0: begin
        st_be    = 4'b0001 << k_q;
        st_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
      end
      2'd1: begin
        st_be    = 4'b0011 << k_q;
        st_wdata = {(DATA_WIDTH/16){wdata_q[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A request accepted in the same cycle as a flush has still reached memory:
  // loads must drain their response, stores simply drop the result.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (capture) state_nxt = op_err ? S_ERR : S_REQ;
      S_REQ: begin
        if (mem_req_ready) state_nxt = is_store_q ? (flush ? S_IDLE : S_DONE) : S_WAIT;
        else if (flush)    state_nxt = S_IDLE;
      end
      S_WAIT: if (mem_rsp_valid) state_nxt = (kill_q || flush) ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      k_q        <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      kill_q     <= 1'b0;
    end else begin
      if (capture) begin
        is_store_q <= op_is_store;
        funct3_q   <= op_funct3;
        k_q        <= op_addr[1:0];
        waddr_q    <= op_addr[MEM_ADDR_WIDTH+1:2];
        wdata_q    <= op_wdata;
        rd_q       <= op_rd;
        result_q   <= '0;
        kill_q     <= 1'b0;
      end
      if (state == S_REQ && mem_req_ready && flush && !is_store_q) kill_q <= 1'b1;
      if (state == S_WAIT) begin
        if (flush) kill_q <= 1'b1;
        if (mem_rsp_valid) begin
          result_q <= load_ext;
          kill_q   <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    op_ready      = (state == S_IDLE);
    mem_req_valid = (state == S_REQ);
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_be    = '0;
    mem_req_wdata = '0;
    if (state == S_REQ) begin
      mem_req_we    = is_store_q;
      mem_req_addr  = waddr_q;
      mem_req_be    = is_store_q ? st_be : 4'b1111;
      mem_req_wdata = is_store_q ? st_wdata : '0;
    end
    res_fire  = (state == S_DONE || state == S_ERR) && !flush;
    res_valid = res_fire;
    res_err   = (state == S_ERR) && !flush;
    res_we    = (state == S_DONE) && !flush && !is_store_q;
    res_data  = ((state == S_DONE) && !flush) ? result_q : '0;
    res_rd    = res_fire ? rd_q : '0;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage of the RV32I core. Sits directly downstream of the decode/execute path that produces the opcode and FUNCT3 classification.
- Takes one load or store per handshake and aligns it onto a word-wide data-memory request/response port.
- Generates byte enables and replicated store data; extracts and sign- or zero-extends load data.
- Flags misaligned or illegal accesses instead of issuing them.

Parameters:
- DATA_WIDTH, 32, data and address width (core_pkg DATA_WIDTH).
- MEM_ADDR_WIDTH, 10, word-address width presented to data memory (core_pkg DATA_MEM_ADDR_WIDTH).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  upstream presents a memory op.
- op_ready  out  1  unit can accept an op; high only in IDLE.
- op_is_store  in  1  1 = store (OPCODE_STORE), 0 = load (OPCODE_LOAD).
- op_funct3  in  3  FUNCT3_LOAD_* / FUNCT3_STORE_* encoding.
- op_addr  in  DATA_WIDTH  effective byte address (ALU result).
- op_wdata  in  DATA_WIDTH  rs2 value for stores.
- op_rd  in  5  destination register, returned with the result.
- flush  in  1  kill the in-flight op (branch/jump redirect).
- mem_req_valid  out  1  request to data memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  write enable.
- mem_req_addr  out  MEM_ADDR_WIDTH  word address = op_addr[MEM_ADDR_WIDTH+1:2].
- mem_req_be  out  4  byte enables.
- mem_req_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_rsp_valid  in  1  read data valid; memory returns exactly one response per accepted load.
- mem_rsp_rdata  in  DATA_WIDTH  read word.
- res_valid  out  1  one-cycle completion pulse.
- res_data  out  DATA_WIDTH  extended load data (0 for stores).
- res_rd  out  5  destination register of the completed op.
- res_we  out  1  write rd; 1 only for successful loads.
- res_err  out  1  misaligned or illegal funct3; no memory access was made.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; all outputs 0 except op_ready=1. All captured op fields cleared to 0.
- Capture: fields are registered on op_valid && op_ready. op_ready is combinational (state==IDLE).
- States:
  - IDLE -> ERR on capture if the access is misaligned or funct3 is illegal.
    - Misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
    - Legal load funct3: 0,1,2,4,5. Legal store funct3: 0,1,2.
  - IDLE -> REQ on any other capture.
  - REQ: mem_req_valid=1, request fields held stable.
    - Request fires on mem_req_ready.
    - Store fires -> DONE. Load fires -> WAIT.
  - WAIT: on mem_rsp_valid -> DONE, with the extracted load data registered.
  - DONE: res_valid=1 for exactly one cycle -> IDLE.
  - ERR: res_valid=1, res_err=1, res_we=0 for one cycle -> IDLE.
- Byte enables and store data (k = addr[1:0]):
  - Byte: be = 4'b0001<<k; wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011<<k; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
  - Loads: mem_req_we=0, be = 4'b1111.
- Load extract: shift rdata right by 8*k, then take the field.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
- Latency:
  - Load, ready and response both zero-wait: capture at edge 0, mem_req_valid high cycle 1, rsp cycle 2, res_valid cycle 3.
  - Store, zero-wait: res_valid cycle 2.
  - Error: res_valid cycle 1.
- Flush:
  - flush in REQ before the request fires: abort -> IDLE, no res_valid. If mem_req_ready and flush coincide, the request still fires (memory has accepted it) and the result is suppressed.
  - flush in WAIT, or a flush suppressing a fired request: set internal kill. Still wait for and consume the response, then go to IDLE with no res_valid. Flushed stores that have already fired are not undone.
  - flush in DONE/ERR: res_valid suppressed that cycle.
  - flush in IDLE: blocks capture that cycle.
- Reset mid-operation: immediate return to IDLE. Memory must be reset together with the unit.

Test Plan:
- LW, addr=0x0000_0010, memory zero-wait returning 0xDEAD_BEEF -> mem_req_addr=4, be=1111, we=0; res_valid at cycle 3 with res_data=0xDEADBEEF, res_we=1.
- LB, addr=0x13, rdata=0x80FF_0000 -> res_data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH, addr=0x06, wdata=0x1234_ABCD, mem_req_ready held low 3 cycles -> request fields stable throughout, be=1100, wdata=0xABCD_ABCD, we=1; res_valid the cycle after acceptance, res_we=0.
- LW at addr=0x02, and a load with funct3=3 -> no mem_req_valid; res_valid+res_err at cycle 1.
- LH, flush asserted in WAIT, response after 2 cycles -> response consumed, no res_valid, op_ready returns the cycle after the response.
- rst_n pulsed low during REQ -> mem_req_valid drops asynchronously, op_ready=1, all outputs 0.
